// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// lab3_isa_pkg
// Shared ISA constants for the Lab3 MIPS datapath: opcode and funct
// encodings, the fetch-unit state encoding and a sign-extension helper.
// ---------------------------------------------------------------------------
package lab3_isa_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_DONE  = 6'h3f;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request, held until acknowledged
//   imem_addr  : byte address of the requested word, stable while imem_req
//   imem_ack   : memory returns imem_rdata this cycle
//   imem_rdata : instruction word
// master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
//   pc_plus4, imm16, jaddr, rs_data : candidate target ingredients
//   Branch, Jump, selectRegorJump   : control-unit selects
//   zero                            : ALU zero flag (bne taken when 0)
//   next_pc                         : selected next PC
// Priority: jr, j/jal, taken bne, fall-through. All arithmetic is modulo
// 2^32 and the low two bits are passed through untouched.
// ---------------------------------------------------------------------------
module next_pc_calc
    import lab3_isa_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        selectRegorJump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] imm_ext_s;
    logic [31:0] branch_off_s;

    assign imm_ext_s    = sign_ext16(imm16);
    assign branch_off_s = {imm_ext_s[29:0], 2'b00};

    // Prioritised next-PC mux
    always_comb begin
        next_pc = pc_plus4;
        if (Jump && selectRegorJump) begin
            next_pc = rs_data;
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], jaddr, 2'b00};
        end else if (Branch && !zero) begin
            next_pc = pc_plus4 + branch_off_s;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// MIPS front end: holds the PC, fetches instructions over the imem bus,
// presents decoded fields while an instruction is held, and advances the PC
// on retire using the control unit's Branch/Jump/selectRegorJump outputs.
// Fetching stops permanently (until reset) on the DONE opcode.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   imem                : instruction-memory bus (master side)
//   instr_valid         : fields below are valid (HOLD state)
//   retire              : execute stage done; sampled only while instr_valid
//   Op,Funct,rs,rt,rd,imm16,jaddr : fields of the held instruction
//   pc_plus4            : PC+4 (JAL link value)
//   Branch,Jump,selectRegorJump,zero,rs_data : next-PC inputs
//   halted              : DONE opcode fetched
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import lab3_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem,
    output logic               instr_valid,
    input  logic               retire,
    output logic [5:0]         Op,
    output logic [5:0]         Funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm16,
    output logic [25:0]        jaddr,
    output logic [31:0]        pc_plus4,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               selectRegorJump,
    input  logic               zero,
    input  logic [31:0]        rs_data,
    output logic               halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  next_pc_s;

    next_pc_calc u_next_pc_calc (
        .pc_plus4        (pc_plus4),
        .imm16           (imm16),
        .jaddr           (jaddr),
        .rs_data         (rs_data),
        .Branch          (Branch),
        .Jump            (Jump),
        .selectRegorJump (selectRegorJump),
        .zero            (zero),
        .next_pc         (next_pc_s)
    );

    // State, PC and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic: ack only matters in FETCH, retire only in HOLD
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d = imem.imem_rdata;
                    if (imem.imem_rdata[31:26] == OP_DONE) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (retire) begin
                    pc_d    = next_pc_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state register so that an
    // asynchronous reset drops imem_req immediately.
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ST_HOLD);
    assign halted         = (state_q == ST_HALT);

    // Field decode of the held instruction
    assign Op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign Funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign jaddr    = ir_q[25:0];
    assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        retire;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc_plus4;
    logic        Branch;
    logic        Jump;
    logic        selectRegorJump;
    logic        zero;
    logic [31:0] rs_data;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Instruction words
    localparam logic [31:0] W_ADD  = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] W_J4   = 32'h0800_0004; // j  0x10
    localparam logic [31:0] W_BNE  = 32'h1422_FFFE; // bne $1,$2,-2
    localparam logic [31:0] W_JR   = 32'h03E0_0008; // jr $31
    localparam logic [31:0] W_JAL  = 32'h0C00_0010; // jal 0x40
    localparam logic [31:0] W_J40  = 32'h0800_0040; // j  jaddr=0x40
    localparam logic [31:0] W_DONE = 32'hFC00_0000; // DONE

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus.master),
        .instr_valid     (instr_valid),
        .retire          (retire),
        .Op              (Op),
        .Funct           (Funct),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .imm16           (imm16),
        .jaddr           (jaddr),
        .pc_plus4        (pc_plus4),
        .Branch          (Branch),
        .Jump            (Jump),
        .selectRegorJump (selectRegorJump),
        .zero            (zero),
        .rs_data         (rs_data),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch with wait_n wait cycles, checking the request each cycle
    task automatic fetch(input logic [31:0] word, input int wait_n,
                         input logic [31:0] exp_addr, input string tag);
        for (int i = 0; i < wait_n; i++) begin
            check({tag, "_req_wait"}, {31'd0, bus.imem_req}, 32'd1);
            check({tag, "_addr_wait"}, bus.imem_addr, exp_addr);
            check({tag, "_valid_wait"}, {31'd0, instr_valid}, 32'd0);
            step();
        end
        check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
        check({tag, "_addr"}, bus.imem_addr, exp_addr);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Retire the held instruction with the given control inputs
    task automatic retire_op(input logic br, input logic jmp, input logic sel,
                             input logic z, input logic [31:0] rsd);
        Branch = br; Jump = jmp; selectRegorJump = sel; zero = z; rs_data = rsd;
        retire = 1'b1;
        step();
        retire = 1'b0;
        Branch = 1'b0; Jump = 1'b0; selectRegorJump = 1'b0; zero = 1'b0;
        rs_data = 32'h0000_0000;
    endtask

    initial begin
        rst_n = 1'b0; retire = 1'b0; Branch = 1'b0; Jump = 1'b0;
        selectRegorJump = 1'b0; zero = 1'b0; rs_data = 32'h0000_0000;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0000_0000;
        step(); step();

        // Reset state
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0000_0000);
        check("rst_op", {26'd0, Op}, 32'd0);
        check("rst_jaddr", {6'd0, jaddr}, 32'd0);

        rst_n = 1'b1;
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        step();

        // Sequential fetch, zero-wait memory
        fetch(W_ADD, 0, 32'h0000_0000, "seq0");
        check("seq0_valid", {31'd0, instr_valid}, 32'd1);
        check("seq0_op", {26'd0, Op}, 32'h00);
        check("seq0_funct", {26'd0, Funct}, 32'h20);
        check("seq0_rs", {27'd0, rs}, 32'd1);
        check("seq0_rt", {27'd0, rt}, 32'd2);
        check("seq0_rd", {27'd0, rd}, 32'd3);
        check("seq0_pc4", pc_plus4, 32'h0000_0004);
        // Hold without retire; a stray ack must not reload IR
        bus.imem_ack = 1'b1; bus.imem_rdata = W_DONE;
        step();
        bus.imem_ack = 1'b0;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_op", {26'd0, Op}, 32'h00);
        check("hold_halted", {31'd0, halted}, 32'd0);
        retire_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("seq_after_retire_valid", {31'd0, instr_valid}, 32'd0);
        fetch(W_ADD, 0, 32'h0000_0004, "seq1");
        check("seq1_valid", {31'd0, instr_valid}, 32'd1);
        check("seq1_funct", {26'd0, Funct}, 32'h20);
        retire_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Wait states: 3 cycles of ack delay at 0x8; retire is ignored meanwhile
        retire = 1'b1;
        fetch(W_ADD, 3, 32'h0000_0008, "wait");
        retire = 1'b0;
        check("wait_valid", {31'd0, instr_valid}, 32'd1);
        retire_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // j 0x10 from 0xC
        fetch(W_J4, 0, 32'h0000_000C, "j4");
        check("j4_jaddr", {6'd0, jaddr}, 32'h4);
        retire_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // bne taken at 0x10 -> 0xC
        fetch(W_BNE, 0, 32'h0000_0010, "bne_t");
        check("bne_imm", {16'd0, imm16}, 32'h0000_FFFE);
        check("bne_op", {26'd0, Op}, 32'h05);
        retire_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // jr back to 0x10 (rs_data takes priority)
        fetch(W_JR, 0, 32'h0000_000C, "jr_back");
        check("jr_funct", {26'd0, Funct}, 32'h08);
        retire_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
        // bne not taken at 0x10 -> 0x14
        fetch(W_BNE, 0, 32'h0000_0010, "bne_nt");
        retire_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        // jr 0x24
        fetch(W_JR, 0, 32'h0000_0014, "jr24");
        retire_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0024);
        // jal at 0x24: link value and jump to 0x40
        fetch(W_JAL, 0, 32'h0000_0024, "jal");
        check("jal_pc4", pc_plus4, 32'h0000_0028);
        check("jal_op", {26'd0, Op}, 32'h03);
        retire_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        // jr into upper region
        fetch(W_JR, 0, 32'h0000_0040, "jr_hi");
        retire_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0000);
        // j jaddr=0x40 at 0x8000_0000 -> 0x8000_0100
        fetch(W_J40, 0, 32'h8000_0000, "j40");
        retire_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        // jr to top of address space, then wrap
        fetch(W_JR, 0, 32'h8000_0100, "jr_top");
        retire_op(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
        fetch(W_ADD, 0, 32'hFFFF_FFFC, "top");
        check("wrap_pc4", pc_plus4, 32'h0000_0000);
        retire_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // Unaligned jr target is passed through
        fetch(W_JR, 0, 32'h0000_0000, "wrap");
        retire_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0022);

        // Halt
        fetch(W_DONE, 0, 32'h0000_0022, "done");
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        retire = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = W_ADD;
        for (int i = 0; i < 20; i++) begin
            check("halt_req", {31'd0, bus.imem_req}, 32'd0);
            step();
        end
        retire = 1'b0; bus.imem_ack = 1'b0;
        check("halt_stay", {31'd0, halted}, 32'd1);

        // Reset mid-fetch at 0x20
        rst_n = 1'b0; step(); rst_n = 1'b1;
        step();
        fetch(W_JR, 0, 32'h0000_0000, "rrst");
        retire_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0020);
        check("pend_req", {31'd0, bus.imem_req}, 32'd1);
        check("pend_addr", bus.imem_addr, 32'h0000_0020);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, bus.imem_req}, 32'd0);
        check("async_addr", bus.imem_addr, 32'h0000_0000);
        check("async_halted", {31'd0, halted}, 32'd0);
        step();
        rst_n = 1'b1;
        check("restart_idle", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("restart_addr", bus.imem_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
